// File: rtl/bus_arbiter_rr.sv
// Round-robin bus arbiter with active-low request/lock/grant signalling.
// Optional tenure limit compiled in when BUS_ARB_TENURE_LIMIT_EN is defined:
// an owner under contention is preempted after MAX_HOLD consecutive grant
// cycles unless it holds its lock_ bit low.
module bus_arbiter_rr #(
    parameter  int N_MASTERS = 4,
    parameter  int MAX_HOLD  = 16,
    localparam int OWNER_W   = ($clog2(N_MASTERS) > 1) ? $clog2(N_MASTERS) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_MASTERS-1:0] req_,
    input  logic [N_MASTERS-1:0] lock_,
    output logic [N_MASTERS-1:0] grnt_,
    output logic [OWNER_W-1:0]   owner,
    output logic                 busy,
    output logic                 preempt
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    logic [0:0]           state;
    logic [0:0]           state_nx;
    logic [OWNER_W-1:0]   owner_nx;
    logic [N_MASTERS-1:0] grnt_nx;
    logic [N_MASTERS-1:0] req;
    logic                 own_req;
    logic                 new_grant;
    logic                 expire;
    logic                 idle_hit;
    logic                 rot_hit;
    logic [OWNER_W-1:0]   idle_idx;
    logic [OWNER_W-1:0]   rot_idx;

    // Next master index, wrapping at N_MASTERS (N need not be a power of two).
    function automatic logic [OWNER_W-1:0] wrap_inc(input logic [OWNER_W-1:0] i);
        return (i == OWNER_W'(N_MASTERS - 1)) ? '0 : i + OWNER_W'(1);
    endfunction

    // First requester scanning start, start+1, ... modulo N; returns {hit, index}.
    function automatic logic [OWNER_W:0] pick(input logic [N_MASTERS-1:0] r,
                                              input logic [OWNER_W-1:0]   start);
        logic [OWNER_W-1:0] j;
        logic [OWNER_W-1:0] idx;
        logic               hit;
        j   = start;
        idx = start;
        hit = 1'b0;
        for (int k = 0; k < N_MASTERS; k++) begin
            if (!hit && r[j]) begin
                hit = 1'b1;
                idx = j;
            end
            j = wrap_inc(j);
        end
        return {hit, idx};
    endfunction

    assign req     = ~req_;
    assign own_req = req[owner];

`ifdef BUS_ARB_TENURE_LIMIT_EN
    localparam int               CNT_W   = $clog2(MAX_HOLD + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_HOLD);

    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     cnt_nx;
    logic [N_MASTERS-1:0] own_mask;
    logic                 competitor;

    // Tenure count saturates so a long lock leaves it pinned at MAX_HOLD.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_MAX) ? c : c + CNT_W'(1);
    endfunction

    // Mask out the owner to see whether anyone else wants the bus.
    always_comb begin
        own_mask        = '0;
        own_mask[owner] = 1'b1;
    end

    assign competitor = |(req & ~own_mask);
    assign expire     = (state == GRANT) && (cnt == CNT_MAX) && lock_[owner] && competitor;

    // Tenure counter: restart on every new grant, clear when the bus goes idle.
    always_comb begin
        cnt_nx = cnt;
        if (state_nx == IDLE)
            cnt_nx = '0;
        else if (new_grant)
            cnt_nx = CNT_W'(1);
        else
            cnt_nx = sat_inc(cnt);
    end

    // Counter and preempt pulse registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            preempt <= 1'b0;
        end else begin
            cnt     <= cnt_nx;
            preempt <= expire && own_req;
        end
    end
`else
    logic unused_cfg;

    // Without the tenure limit lock_ and MAX_HOLD have no effect.
    assign expire     = 1'b0;
    assign preempt    = 1'b0;
    assign unused_cfg = ^lock_ ^ (MAX_HOLD > 255);
`endif

    // Arbitration decision: idle scans from owner, rotation scans from owner+1.
    always_comb begin
        state_nx  = state;
        owner_nx  = owner;
        new_grant = 1'b0;
        {idle_hit, idle_idx} = pick(req, owner);
        {rot_hit, rot_idx}   = pick(req, wrap_inc(owner));
        if (state == IDLE) begin
            if (idle_hit) begin
                state_nx  = GRANT;
                owner_nx  = idle_idx;
                new_grant = 1'b1;
            end
        end else if (!own_req || expire) begin
            if (rot_hit) begin
                owner_nx  = rot_idx;
                new_grant = 1'b1;
            end else begin
                state_nx = IDLE;
            end
        end
    end

    // Grant vector follows the next state so it is registered with the decision.
    always_comb begin
        grnt_nx = '1;
        if (state_nx == GRANT)
            grnt_nx[owner_nx] = 1'b0;
    end

    // Arbiter state registers; reset drops any grant immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            owner <= '0;
            grnt_ <= '1;
            busy  <= 1'b0;
        end else begin
            state <= state_nx;
            owner <= owner_nx;
            grnt_ <= grnt_nx;
            busy  <= (state_nx == GRANT);
        end
    end

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Directed bench for bus_arbiter_rr with N_MASTERS=4, MAX_HOLD=4.
// Expectations for the tenure tests depend on BUS_ARB_TENURE_LIMIT_EN.
module tb_bus_arbiter_rr;

`ifdef BUS_ARB_TENURE_LIMIT_EN
    localparam bit TEN = 1'b1;
`else
    localparam bit TEN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req_;
    logic [3:0] lock_;
    logic [3:0] grnt_;
    logic [1:0] owner;
    logic       busy;
    logic       preempt;

    int n_checks = 0;
    int n_pass   = 0;

    logic [3:0] rot_req [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [1:0] rot_own [4] = '{2'd2, 2'd3, 2'd0, 2'd1};
    logic [3:0] rot_gnt [4] = '{4'b1011, 4'b0111, 4'b1110, 4'b1101};

    always #5 clk = ~clk;

    bus_arbiter_rr #(.N_MASTERS(4), .MAX_HOLD(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .req_    (req_),
        .lock_   (lock_),
        .grnt_   (grnt_),
        .owner   (owner),
        .busy    (busy),
        .preempt (preempt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        req_  = 4'hF;
        lock_ = 4'hF;
        #2;
        check("rst_grnt", grnt_, 4'hF);
        check("rst_owner", owner, 2'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_preempt", preempt, 1'b0);
        step();
        step();
        reset = 1'b0;

        // single requester, one-cycle latency
        req_ = 4'b1011;
        check("lat_before", grnt_, 4'hF);
        step();
        check("first_grnt", grnt_, 4'b1011);
        check("first_owner", owner, 2'd2);
        check("first_busy", busy, 1'b1);

        // all release: idle with owner kept, then same master back
        req_ = 4'hF;
        step();
        check("idle_grnt", grnt_, 4'hF);
        check("idle_busy", busy, 1'b0);
        check("idle_owner", owner, 2'd2);
        req_ = 4'b1011;
        step();
        check("regrant_grnt", grnt_, 4'b1011);
        check("regrant_owner", owner, 2'd2);

        // idle scan starts at last owner: 0 and 3 request, 3 wins
        req_ = 4'hF;
        step();
        req_ = 4'b0110;
        step();
        check("idle_scan_owner", owner, 2'd3);
        check("idle_scan_grnt", grnt_, 4'b0111);

        // round robin rotation on successive releases
        req_ = 4'hF;
        step();
        req_ = 4'b1101;
        step();
        check("rr_start_owner", owner, 2'd1);
        for (int i = 0; i < 4; i++) begin
            req_ = rot_req[i];
            step();
            check("rr_owner", owner, rot_own[i]);
            check("rr_grnt", grnt_, rot_gnt[i]);
            check("rr_preempt", preempt, 1'b0);
        end

        // asynchronous reset mid-grant
        req_ = 4'b1101;
        #3;
        reset = 1'b1;
        #1;
        check("async_rst_grnt", grnt_, 4'hF);
        check("async_rst_owner", owner, 2'd0);
        check("async_rst_busy", busy, 1'b0);
        req_ = 4'hF;
        step();
        step();
        check("rst_hold_grnt", grnt_, 4'hF);
        reset = 1'b0;

        // masters 0 and 3 contend: scan restarts at 0, tenure expiry to 3
        req_ = 4'b0110;
        step();
        check("ten_first_owner", owner, 2'd0);
        check("ten_first_grnt", grnt_, 4'b1110);
        for (int k = 1; k < 4; k++) begin
            step();
            check("ten_hold_grnt", grnt_, 4'b1110);
            check("ten_hold_preempt", preempt, 1'b0);
        end
        step();
        check("ten_exp_grnt", grnt_, TEN ? 4'b0111 : 4'b1110);
        check("ten_exp_owner", owner, TEN ? 2'd3 : 2'd0);
        check("ten_exp_preempt", preempt, TEN);
        step();
        check("ten_after_grnt", grnt_, TEN ? 4'b0111 : 4'b1110);
        check("ten_after_preempt", preempt, 1'b0);

        // lock holds the grant past the tenure limit
        req_ = 4'b1110;
        step();
        check("lock_start_owner", owner, 2'd0);
        req_  = 4'b0110;
        lock_ = 4'b1110;
        for (int k = 0; k < 10; k++) begin
            step();
            check("lock_owner", owner, 2'd0);
            check("lock_preempt", preempt, 1'b0);
        end
        lock_ = 4'hF;
        step();
        check("unlock_owner", owner, TEN ? 2'd3 : 2'd0);
        check("unlock_grnt", grnt_, TEN ? 4'b0111 : 4'b1110);
        check("unlock_preempt", preempt, TEN);

        // lone requester is never preempted
        req_ = 4'b0111;
        step();
        check("lone_owner", owner, 2'd3);
        for (int k = 0; k < 8; k++) begin
            step();
            check("lone_grnt", grnt_, 4'b0111);
            check("lone_preempt", preempt, 1'b0);
        end

        req_ = 4'hF;
        step();
        check("final_busy", busy, 1'b0);
        check("final_owner", owner, 2'd3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
